// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture path.
// The default width is the same one the PWM generator uses.
package pwm_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_COUNT     = (1 << DEFAULT_WIDTH) - 1;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

endpackage

// File: rtl/pwm_edge_detect.sv
// Input synchronizer and rising-edge detector for the PWM capture input.
// The s_o and rise_o outputs are registered together, so they always refer to the same sample.
module pwm_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic in_i,
    output logic s_o,
    output logic rise_o
);

    logic s;
    logic s_q;
    logic rise_q;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = in_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clock) begin
                sync_q[0] <= in_i;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Left out of reset: a line that is high through reset must not produce a false rise afterwards.
    always_ff @(posedge clock) begin
        s_q    <= s;
        rise_q <= s & ~s_q;
    end

    assign s_o    = s_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures the period and high time of an incoming PWM waveform in clock cycles.
// Each measurement covers the window from one rising edge up to the next.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_en,
    input  logic             io_in,
    output logic [WIDTH-1:0] io_period,
    output logic [WIDTH-1:0] io_duty,
    output logic             io_valid,
    output logic             io_timeout,
    output logic [WIDTH-1:0] io_count
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic s;
    logic rise;

    state_e           state_q,      state_d;
    logic [WIDTH-1:0] cnt_period_q, cnt_period_d;
    logic [WIDTH-1:0] cnt_high_q,   cnt_high_d;
    logic [WIDTH-1:0] period_q,     period_d;
    logic [WIDTH-1:0] duty_q,       duty_d;
    logic             valid_q,      valid_d;
    logic             timeout_q,    timeout_d;

    pwm_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clock (clock),
        .in_i  (io_in),
        .s_o   (s),
        .rise_o(rise)
    );

    always_comb begin
        state_d      = state_q;
        cnt_period_d = cnt_period_q;
        cnt_high_d   = cnt_high_q;
        period_d     = period_q;
        duty_d       = duty_q;
        valid_d      = 1'b0;
        timeout_d    = timeout_q;

        if (!io_en) begin
            state_d      = IDLE;
            cnt_period_d = '0;
            cnt_high_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d      = MEASURE;
                        cnt_period_d = WIDTH'(1);
                        cnt_high_d   = WIDTH'(1);
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d     = cnt_period_q;
                        duty_d       = cnt_high_q;
                        valid_d      = 1'b1;
                        timeout_d    = 1'b0;
                        cnt_period_d = WIDTH'(1);
                        cnt_high_d   = WIDTH'(1);
                    end else if (cnt_period_q < CNT_MAX) begin
                        cnt_period_d = cnt_period_q + WIDTH'(1);
                        cnt_high_d   = cnt_high_q + {{(WIDTH-1){1'b0}}, s};
                    end else begin
                        // No edge for a full counter range: give up and wait for a fresh rise.
                        state_d      = IDLE;
                        timeout_d    = 1'b1;
                        cnt_period_d = '0;
                        cnt_high_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_period_q <= '0;
            cnt_high_q   <= '0;
            period_q     <= '0;
            duty_q       <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_period_q <= cnt_period_d;
            cnt_high_q   <= cnt_high_d;
            period_q     <= period_d;
            duty_q       <= duty_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign io_period  = period_q;
    assign io_duty    = duty_q;
    assign io_valid   = valid_q;
    assign io_timeout = timeout_q;
    assign io_count   = cnt_period_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: PWM waveforms are driven pin-by-pin, a reference model predicts each
// measurement from the rising-edge times, and a monitor process compares every io_valid pulse.
module tb_pwm_capture;

    localparam int WIDTH = 8;
    localparam int S     = 2;
    localparam int MAXC  = (1 << WIDTH) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             io_en;
    logic             io_in;
    logic [WIDTH-1:0] io_period;
    logic [WIDTH-1:0] io_duty;
    logic             io_valid;
    logic             io_timeout;
    logic [WIDTH-1:0] io_count;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    pwm_capture #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(S)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .io_en     (io_en),
        .io_in     (io_in),
        .io_period (io_period),
        .io_duty   (io_duty),
        .io_valid  (io_valid),
        .io_timeout(io_timeout),
        .io_count  (io_count)
    );

    typedef struct {
        int p;
        int d;
        int c;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state, kept in pin-level terms.
    bit prev_pin    = 1'b0;
    bit have_rise   = 1'b0;
    bit exp_timeout = 1'b0;
    int last_rise   = 0;
    int hi_cnt      = 0;
    int exp_per     = 0;
    int exp_dut     = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one clock cycle of pin/enable/reset and advance the model.
    task automatic step(input bit v, input bit en_v, input bit rst_v);
        exp_t e;
        @(negedge clock);
        io_in = v;
        io_en = en_v;
        reset = rst_v;
        if (rst_v || !en_v) begin
            have_rise = 1'b0;
            if (rst_v) begin
                exp_timeout = 1'b0;
                exp_per     = 0;
                exp_dut     = 0;
            end
        end else if (v && !prev_pin) begin
            if (have_rise) begin
                e.p = cyc - last_rise;
                e.d = hi_cnt;
                e.c = cyc + S + 2;
                sb.push_back(e);
                exp_per     = e.p;
                exp_dut     = e.d;
                exp_timeout = 1'b0;
            end
            have_rise = 1'b1;
            last_rise = cyc;
            hi_cnt    = 0;
        end else if (have_rise && (cyc - last_rise) >= MAXC) begin
            have_rise   = 1'b0;
            exp_timeout = 1'b1;
        end
        if (v) hi_cnt++;
        prev_pin = v;
    endtask

    task automatic wave(input int p, input int d, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < p; i++) begin
                step(i < d, 1'b1, 1'b0);
            end
        end
    endtask

    task automatic checkpoint(input string tag);
        chk({tag, "_period"},  int'(io_period),  exp_per);
        chk({tag, "_duty"},    int'(io_duty),    exp_dut);
        chk({tag, "_timeout"}, int'(io_timeout), int'(exp_timeout));
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (io_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", int'(io_valid), 0);
                end else begin
                    e = sb.pop_front();
                    chk("valid_period", int'(io_period), e.p);
                    chk("valid_duty",   int'(io_duty),   e.d);
                    chk("valid_cycle",  cyc,             e.c);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d, expected under 5000", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        int d;
        io_in = 1'b0;
        io_en = 1'b1;
        reset = 1'b1;
        fork
            monitor();
        join_none

        // Power-on reset.
        repeat (5) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("por_period",  int'(io_period),  0);
        chk("por_duty",    int'(io_duty),    0);
        chk("por_valid",   int'(io_valid),   0);
        chk("por_timeout", int'(io_timeout), 0);
        chk("por_count",   int'(io_count),   0);

        // Steady waveform, then a setting change at a period boundary.
        wave(10, 3, 5);
        checkpoint("p10d3");
        wave(20, 15, 4);
        checkpoint("p20d15");

        // Random periods and duties.
        repeat (30) begin
            p = int'($urandom_range(2, 40));
            d = int'($urandom_range(1, p - 1));
            wave(p, d, 1);
        end

        // Enable dropped mid-period while high, raised again while still high.
        repeat (6) step(1'b0, 1'b1, 1'b0);
        repeat (8) step(1'b1, 1'b1, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        chk("en_low_count", int'(io_count), 0);
        chk("en_low_valid", int'(io_valid), 0);
        repeat (7)  step(1'b1, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b0);
        wave(30, 20, 3);
        checkpoint("reenable");

        // Constant high after one rise: timeout, then recovery.
        wave(10, 4, 2);
        repeat (300) step(1'b1, 1'b1, 1'b0);
        checkpoint("timeout");
        chk("timeout_count", int'(io_count), 0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        wave(16, 5, 3);
        checkpoint("recover");

        // Reset four cycles into a P=12, D=6 period.
        step(1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("rst_period",  int'(io_period),  0);
        chk("rst_duty",    int'(io_duty),    0);
        chk("rst_valid",   int'(io_valid),   0);
        chk("rst_timeout", int'(io_timeout), 0);
        chk("rst_count",   int'(io_count),   0);
        repeat (6) step(1'b0, 1'b1, 1'b0);
        wave(12, 6, 3);
        checkpoint("after_rst");

        // Minimum waveform P=2, D=1.
        repeat (4) step(1'b0, 1'b1, 1'b0);
        wave(2, 1, 10);
        repeat (10) step(1'b0, 1'b1, 1'b0);
        checkpoint("min");
        chk("pending", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
